// File: rtl/n_tick_gen.sv
// Programmable down-counting strobe generator.
// Loaded with a period P, it decrements on en-qualified cycles and issues a
// registered one-cycle tick every P counts, either periodically or once.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | stopped; count and busy hold, en ignored, tick low
// ST_RUN   | counting down on en; tick at terminal count (count==1)
module n_tick_gen #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic         load,
   input  logic [N-1:0] load_val,
   input  logic         oneshot,
   output logic [N-1:0] count,
   output logic         tick,
   output logic         busy
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] ZERO = '0;

   logic [0:0]   r_state;
   logic [N-1:0] r_count;
   logic [N-1:0] r_period;
   logic         r_mode;
   logic         r_tick;

   logic         w_terminal;
   logic         w_load_nonzero;

   // Terminal count is the last qualified cycle of a period; zero is never
   // decremented, so the counter cannot wrap.
   assign w_terminal     = (r_count == ONE);
   assign w_load_nonzero = (load_val != ZERO);

   // Counter, period/mode capture and IDLE/RUN sequencing.
   // Priority: reset > load > en-decrement > hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_count  <= ZERO;
         r_period <= ZERO;
         r_mode   <= 1'b0;
         r_tick   <= 1'b0;
      end else if (load) begin
         // A load on a terminal cycle simply restarts; the old tick is dropped.
         r_count  <= load_val;
         r_period <= load_val;
         r_mode   <= oneshot;
         r_tick   <= 1'b0;
         r_state  <= w_load_nonzero ? ST_RUN : ST_IDLE;
      end else if ((r_state == ST_RUN) && en) begin
         if (w_terminal) begin
            r_tick <= 1'b1;
            if (r_mode) begin
               r_count <= ZERO;
               r_state <= ST_IDLE;
            end else begin
               r_count <= r_period;
            end
         end else begin
            r_tick <= 1'b0;
            if (r_count != ZERO) begin
               r_count <= r_count - ONE;
            end
         end
      end else begin
         r_tick <= 1'b0;
      end
   end

   assign count = r_count;
   assign tick  = r_tick;
   assign busy  = (r_state == ST_RUN);

endmodule

// File: tb/tb_n_tick_gen.sv
// Directed vector bench for n_tick_gen: a per-cycle table of inputs and
// hand-computed outputs, plus a hand-written full-scale period sequence.
module tb_n_tick_gen;

   logic       clk;
   logic       reset;
   logic       en;
   logic       load;
   logic [7:0] load_val;
   logic       oneshot;
   logic [7:0] count;
   logic       tick;
   logic       busy;

   int n_pass;
   int n_total;

   typedef struct {
      logic       rst;
      logic       ld;
      logic       e;
      logic [7:0] val;
      logic       os;
      logic [7:0] c;
      logic       t;
      logic       b;
      string      nm;
   } vec_t;

   vec_t vecs[$];

   n_tick_gen #(.N(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .load     (load),
      .load_val (load_val),
      .oneshot  (oneshot),
      .count    (count),
      .tick     (tick),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic add(input logic rst, input logic ld, input logic e,
                      input logic [7:0] val, input logic os,
                      input logic [7:0] c, input logic t, input logic b,
                      input string nm);
      vec_t v;
      v.rst = rst; v.ld = ld; v.e = e; v.val = val; v.os = os;
      v.c = c; v.t = t; v.b = b; v.nm = nm;
      vecs.push_back(v);
   endtask

   // Apply inputs, take one rising edge, then sample 1 time unit later.
   task automatic drive(input logic rst, input logic ld, input logic e,
                        input logic [7:0] val, input logic os);
      reset    = rst;
      load     = ld;
      en       = e;
      load_val = val;
      oneshot  = os;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [7:0] c, input logic t,
                      input logic b);
      n_total++;
      if (count !== c || tick !== t || busy !== b) begin
         $display("FAIL %s: got count=%0d tick=%0b busy=%0b, expected count=%0d tick=%0b busy=%0b",
                  nm, count, tick, busy, c, t, b);
      end else begin
         n_pass++;
      end
   endtask

   initial begin
      n_pass   = 0;
      n_total  = 0;
      reset    = 1'b1;
      load     = 1'b0;
      en       = 1'b0;
      load_val = 8'd0;
      oneshot  = 1'b0;

      //   rst ld en val    os   count  t  b   name
      // 1: reset beats load and en
      add(1, 1, 1, 8'd5, 0, 8'd0, 0, 0, "reset0");
      add(1, 1, 1, 8'd5, 0, 8'd0, 0, 0, "reset1");
      // 2: periodic /4
      add(0, 1, 1, 8'd4, 0, 8'd4, 0, 1, "per4_load");
      add(0, 0, 1, 8'd0, 0, 8'd3, 0, 1, "per4_e1");
      add(0, 0, 1, 8'd0, 0, 8'd2, 0, 1, "per4_e2");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "per4_e3");
      add(0, 0, 1, 8'd0, 0, 8'd4, 1, 1, "per4_e4");
      add(0, 0, 1, 8'd0, 0, 8'd3, 0, 1, "per4_e5");
      add(0, 0, 1, 8'd0, 0, 8'd2, 0, 1, "per4_e6");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "per4_e7");
      add(0, 0, 1, 8'd0, 0, 8'd4, 1, 1, "per4_e8");
      // 3: one-shot 3
      add(0, 1, 1, 8'd3, 1, 8'd3, 0, 1, "os3_load");
      add(0, 0, 1, 8'd0, 0, 8'd2, 0, 1, "os3_e1");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "os3_e2");
      add(0, 0, 1, 8'd0, 0, 8'd0, 1, 0, "os3_e3");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "os3_after1");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "os3_after2");
      // 4: en gaps stretch the period
      add(0, 1, 0, 8'd2, 0, 8'd2, 0, 1, "gap_load");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "gap_e1");
      add(0, 0, 0, 8'd0, 0, 8'd1, 0, 1, "gap_hold1");
      add(0, 0, 0, 8'd0, 0, 8'd1, 0, 1, "gap_hold2");
      add(0, 0, 1, 8'd0, 0, 8'd2, 1, 1, "gap_e2");
      add(0, 0, 0, 8'd0, 0, 8'd2, 0, 1, "gap_hold3");
      // 5a: load 0 stops
      add(0, 1, 1, 8'd0, 0, 8'd0, 0, 0, "p0_load");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "p0_e1");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "p0_e2");
      // 5b: P=1 periodic ticks every en cycle
      add(0, 1, 1, 8'd1, 0, 8'd1, 0, 1, "p1_load");
      add(0, 0, 1, 8'd0, 0, 8'd1, 1, 1, "p1_e1");
      add(0, 0, 1, 8'd0, 0, 8'd1, 1, 1, "p1_e2");
      add(0, 0, 0, 8'd0, 0, 8'd1, 0, 1, "p1_gap");
      add(0, 0, 1, 8'd0, 0, 8'd1, 1, 1, "p1_e3");
      // 6a: load on the terminal cycle restarts without a tick
      add(0, 1, 1, 8'd3, 0, 8'd3, 0, 1, "col_load3");
      add(0, 0, 1, 8'd0, 0, 8'd2, 0, 1, "col_e1");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "col_e2");
      add(0, 1, 1, 8'd5, 0, 8'd5, 0, 1, "col_load5");
      add(0, 0, 1, 8'd0, 0, 8'd4, 0, 1, "col_e3");
      // 6b: reset mid-RUN
      add(0, 1, 1, 8'd2, 0, 8'd2, 0, 1, "rst_load2");
      add(0, 0, 1, 8'd0, 0, 8'd1, 0, 1, "rst_e1");
      add(1, 0, 1, 8'd0, 0, 8'd0, 0, 0, "rst_mid");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "rst_idle1");
      add(0, 0, 1, 8'd0, 0, 8'd0, 0, 0, "rst_idle2");

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].ld, vecs[i].e, vecs[i].val, vecs[i].os);
         chk(vecs[i].nm, vecs[i].c, vecs[i].t, vecs[i].b);
      end

      // Full-scale period: first tick after 255 en cycles, then reload to 255.
      drive(0, 1, 1, 8'hFF, 0);
      chk("ff_load", 8'hFF, 0, 1);
      for (int k = 1; k <= 254; k++) begin
         drive(0, 0, 1, 8'd0, 0);
         chk("ff_run", 8'(255 - k), 0, 1);
      end
      drive(0, 0, 1, 8'd0, 0);
      chk("ff_tick", 8'hFF, 1, 1);
      drive(0, 0, 1, 8'd0, 0);
      chk("ff_next", 8'hFE, 0, 1);

      // One-shot followed by a fresh periodic load reuses the block cleanly.
      drive(0, 1, 1, 8'd1, 1);
      chk("os1_load", 8'd1, 0, 1);
      drive(0, 0, 1, 8'd0, 0);
      chk("os1_tick", 8'd0, 1, 0);
      drive(0, 0, 1, 8'd0, 0);
      chk("os1_idle", 8'd0, 0, 0);
      drive(0, 1, 0, 8'd2, 0);
      chk("reuse_load", 8'd2, 0, 1);
      drive(0, 0, 1, 8'd0, 0);
      chk("reuse_e1", 8'd1, 0, 1);
      drive(0, 0, 1, 8'd0, 0);
      chk("reuse_e2", 8'd2, 1, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
